// File: rtl/gf_pkg.sv
// gf_pkg: shared GF(2^M) constants, mode encoding and reduction-matrix builder.
package gf_pkg;

    localparam int         GF_M_DEFAULT    = 8;
    localparam logic [8:0] GF_POLY_DEFAULT = 9'h11D;

    typedef enum logic {
        GF_MODE_MUL = 1'b0,
        GF_MODE_MAC = 1'b1
    } gf_mode_e;

    // Row i holds x^(M+i) mod POLY; sized for the largest supported field.
    typedef logic [14:0][15:0] red_mat_t;

    function automatic red_mat_t gf_red_matrix(input int m, input logic [16:0] poly);
        red_mat_t    mat;
        logic [16:0] r;
        mat = '0;
        r   = poly ^ (17'h1 << m);
        for (int i = 0; i < m - 1; i++) begin
            mat[i] = r[15:0];
            r      = r << 1;
            if (r[m]) r = r ^ poly;
        end
        return mat;
    endfunction

endpackage

// File: rtl/gf2m_reduce.sv
// gf2m_reduce: combinational reduction of a (2M-1)-bit carry-less product mod POLY.
module gf2m_reduce
    import gf_pkg::*;
#(
    parameter int         M    = GF_M_DEFAULT,
    parameter logic [M:0] POLY = GF_POLY_DEFAULT
) (
    input  logic [2*M-2:0] prod_i,
    output logic [M-1:0]   res_o
);

    localparam red_mat_t RED = gf_red_matrix(M, 17'(POLY));

    always_comb begin
        res_o = prod_i[M-1:0];
        for (int i = 0; i < M - 1; i++)
            if (prod_i[M+i]) res_o = res_o ^ RED[i][M-1:0];
    end

endmodule

// File: rtl/gf2m_mac_pipe.sv
// gf2m_mac_pipe: two-stage GF(2^M) multiplier / multiply-accumulator with valid/ready on both sides.
module gf2m_mac_pipe
    import gf_pkg::*;
#(
    parameter int         M    = GF_M_DEFAULT,
    parameter logic [M:0] POLY = GF_POLY_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] in_a,
    input  logic [M-1:0] in_b,
    input  logic         in_mode,
    input  logic         in_first,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] out_data,
    output logic         acc_open
);

    localparam int PW = 2 * M - 1;

    logic          advance, accept;
    logic [PW-1:0] prod;
    logic [M-1:0]  red, sum;
    logic          emit_mul, mac, emit;

    logic          s1_valid_q, s1_valid_d;
    logic [PW-1:0] s1_prod_q, s1_prod_d;
    gf_mode_e      s1_mode_q, s1_mode_d;
    logic          s1_first_q, s1_first_d;
    logic          s1_last_q, s1_last_d;
    logic          out_valid_q, out_valid_d;
    logic [M-1:0]  out_data_q, out_data_d;
    logic [M-1:0]  acc_q, acc_d;
    logic          acc_open_q, acc_open_d;

    // A stalled output freezes both stages so nothing is dropped or duplicated.
    assign advance = !out_valid_q || out_ready;
    assign accept  = in_valid && advance;

    always_comb begin
        prod = '0;
        for (int i = 0; i < M; i++)
            if (in_b[i]) prod = prod ^ (PW'(in_a) << i);
    end

    gf2m_reduce #(.M(M), .POLY(POLY)) u_reduce (
        .prod_i (s1_prod_q),
        .res_o  (red)
    );

    assign sum      = (s1_first_q ? '0 : acc_q) ^ red;
    assign emit_mul = s1_valid_q && (s1_mode_q == GF_MODE_MUL);
    assign mac      = s1_valid_q && (s1_mode_q == GF_MODE_MAC);
    assign emit     = emit_mul || (mac && s1_last_q);

    assign s1_valid_d  = advance ? accept : s1_valid_q;
    assign s1_prod_d   = accept ? prod : s1_prod_q;
    assign s1_mode_d   = accept ? gf_mode_e'(in_mode) : s1_mode_q;
    assign s1_first_d  = accept ? in_first : s1_first_q;
    assign s1_last_d   = accept ? in_last : s1_last_q;
    assign out_valid_d = advance ? emit : out_valid_q;
    assign out_data_d  = (advance && emit) ? (emit_mul ? red : sum) : out_data_q;
    assign acc_d       = (advance && mac) ? (s1_last_q ? '0 : sum) : acc_q;
    assign acc_open_d  = (advance && mac) ? (!s1_last_q && (s1_first_q || acc_open_q)) : acc_open_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_prod_q   <= '0;
            s1_mode_q   <= GF_MODE_MUL;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            acc_q       <= '0;
            acc_open_q  <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_prod_q   <= s1_prod_d;
            s1_mode_q   <= s1_mode_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            acc_q       <= acc_d;
            acc_open_q  <= acc_open_d;
        end
    end

    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign acc_open  = acc_open_q;

endmodule

// File: tb/tb_gf2m_mac_pipe.sv
// tb_gf2m_mac_pipe: directed checks of an M=8 and an M=4 instance against hand values and a shift-and-add model.
module tb_gf2m_mac_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       v8, rdy8, mode8, first8, last8, ov8, or8, ao8;
    logic [7:0] a8, b8, od8;
    logic       v4, rdy4, mode4, first4, last4, ov4, or4, ao4;
    logic [3:0] a4, b4, od4;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gf2m_mac_pipe dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_a(a8), .in_b(b8),
        .in_mode(mode8), .in_first(first8), .in_last(last8), .out_valid(ov8),
        .out_ready(or8), .out_data(od8), .acc_open(ao8)
    );

    gf2m_mac_pipe #(.M(4), .POLY(5'h13)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in_a(a4), .in_b(b4),
        .in_mode(mode4), .in_first(first4), .in_last(last4), .out_valid(ov4),
        .out_ready(or4), .out_data(od4), .acc_open(ao4)
    );

    function automatic logic [15:0] gmul(input int m, input logic [16:0] poly,
                                         input logic [15:0] a, input logic [15:0] b);
        logic [16:0] aa, p;
        p  = '0;
        aa = {1'b0, a};
        for (int i = 0; i < m; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa << 1;
            if (aa[m]) aa = aa ^ poly;
        end
        return p[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic d8(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic mode, input logic first, input logic last);
        v8 = v; a8 = a; b8 = b; mode8 = mode; first8 = first; last8 = last;
    endtask

    logic [7:0] q8[$];
    logic [3:0] q4[$];
    logic [7:0] held;
    logic       m_s1v, m_ov, adv, stalled;
    int         sent, got;

    initial begin
        rst = 1'b1;
        d8(0, 0, 0, 0, 0, 0);
        or8 = 1'b1;
        v4 = 0; a4 = 0; b4 = 0; mode4 = 0; first4 = 0; last4 = 0; or4 = 1'b1;
        #3;
        chk("rst_out_valid", ov8, 0);
        chk("rst_out_data", od8, 0);
        chk("rst_acc_open", ao8, 0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", rdy8, 1);

        // MUL back-to-back
        d8(1, 8'h02, 8'h80, 0, 0, 0); tick();
        chk("mul_lat_ov", ov8, 0);
        d8(1, 8'h80, 8'h80, 0, 1, 1); tick();
        chk("mul0_ov", ov8, 1);
        chk("mul0_data", od8, 8'h1D);
        d8(1, 8'h00, 8'hFF, 0, 0, 0); tick();
        chk("mul1_ov", ov8, 1);
        chk("mul1_data", od8, 8'h13);
        d8(0, 0, 0, 0, 0, 0); tick();
        chk("mul2_ov", ov8, 1);
        chk("mul2_data", od8, 8'h00);
        chk("mul_acc_open", ao8, 0);
        tick();
        chk("mul_idle_ov", ov8, 0);

        // MAC 3-term sequence
        d8(1, 8'h02, 8'h80, 1, 1, 0); tick();
        chk("mac_t0_ov", ov8, 0);
        d8(1, 8'h80, 8'h80, 1, 0, 0); tick();
        chk("mac_t1_ov", ov8, 0);
        chk("mac_t1_open", ao8, 1);
        d8(1, 8'h01, 8'h55, 1, 0, 1); tick();
        chk("mac_t2_ov", ov8, 0);
        chk("mac_t2_open", ao8, 1);
        d8(0, 0, 0, 0, 0, 0); tick();
        chk("mac_sum_ov", ov8, 1);
        chk("mac_sum_data", od8, 8'h5B);
        chk("mac_sum_open", ao8, 0);
        tick();
        chk("mac_after_ov", ov8, 0);

        // Backpressure with out_ready pattern 1,0,0 and a tiny handshake model
        m_s1v = 0; m_ov = 0; sent = 0; got = 0; stalled = 0; held = '0;
        for (int c = 0; c < 60 && got < 6; c++) begin
            or8 = (c % 3) == 0;
            if (sent < 6) d8(1, 8'(8'h21 * (sent + 1)), 8'(8'h35 + sent * 7), 0, 0, 0);
            else d8(0, 0, 0, 0, 0, 0);
            #1;
            adv = !m_ov || or8;
            chk("bp_in_ready", rdy8, adv);
            chk("bp_out_valid", ov8, m_ov);
            if (stalled) chk("bp_hold_data", od8, held);
            if (v8 && adv) begin
                q8.push_back(gmul(8, 17'h11D, 16'(a8), 16'(b8)));
                sent++;
            end
            if (ov8 && or8) begin
                chk("bp_data", od8, q8.pop_front());
                got++;
            end
            stalled = ov8 && !or8;
            held = od8;
            if (adv) begin m_ov = m_s1v; m_s1v = v8; end
            @(posedge clk);
            #1;
        end
        chk("bp_all_retired", got, 6);
        d8(0, 0, 0, 0, 0, 0);
        or8 = 1'b1;
        tick(); tick();

        // Interleave MUL into open MAC, then restart with first+last
        d8(1, 8'h02, 8'h80, 1, 1, 0); tick();
        d8(1, 8'h03, 8'h03, 0, 1, 1); tick();
        chk("il_open", ao8, 1);
        chk("il_ov0", ov8, 0);
        d8(1, 8'h04, 8'h04, 1, 1, 1); tick();
        chk("il_mul_ov", ov8, 1);
        chk("il_mul_data", od8, 8'h05);
        chk("il_mul_open", ao8, 1);
        d8(0, 0, 0, 0, 0, 0); tick();
        chk("il_restart_ov", ov8, 1);
        chk("il_restart_data", od8, 8'h10);
        chk("il_restart_open", ao8, 0);
        tick();

        // Async reset with an open sequence and a stalled result
        d8(1, 8'h02, 8'h80, 1, 1, 0); tick();
        d8(1, 8'h03, 8'h03, 0, 0, 0); tick();
        d8(0, 0, 0, 0, 0, 0); or8 = 1'b0; tick();
        chk("pre_rst_ov", ov8, 1);
        chk("pre_rst_open", ao8, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ov", ov8, 0);
        chk("async_rst_open", ao8, 0);
        chk("async_rst_data", od8, 0);
        rst = 1'b0; or8 = 1'b1;
        tick();
        d8(1, 8'h02, 8'h80, 1, 1, 1); tick();
        d8(0, 0, 0, 0, 0, 0); tick();
        chk("post_rst_ov", ov8, 1);
        chk("post_rst_data", od8, 8'h1D);
        tick();

        // M=4 instance
        v4 = 1; a4 = 4'h8; b4 = 4'h2; tick();
        a4 = 4'hF; b4 = 4'hF; tick();
        v4 = 0;
        chk("m4_a_ov", ov4, 1);
        chk("m4_a_data", od4, 4'h3);
        tick();
        chk("m4_b_data", od4, 4'hA);
        tick();
        chk("m4_idle_ov", ov4, 0);

        sent = 0; got = 0;
        for (int c = 0; c < 4000 && got < 1000; c++) begin
            v4  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            a4  = 4'($urandom);
            b4  = 4'($urandom);
            or4 = $urandom_range(0, 3) != 0;
            #1;
            if (v4 && rdy4) begin
                q4.push_back(gmul(4, 17'h13, 16'(a4), 16'(b4)));
                sent++;
            end
            if (ov4 && or4) begin
                chk("m4_rand", od4, q4.pop_front());
                got++;
            end
            @(posedge clk);
            #1;
        end
        chk("m4_rand_count", got, 1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gf2m_mac_pipe.md
Name: gf2m_mac_pipe

Overview:
Pipelined GF(2^M) multiplier/multiply-accumulator with a parametrised field width and primitive polynomial, plus valid/ready handshakes on both sides.
- MUL mode: returns A*B mod POLY for every accepted beat.
- MAC mode: XOR-accumulates products over a framed sequence and emits one sum per sequence.
- Serves the RS encoder/decoder datapaths (syndrome, Chien, Forney evaluation) that currently instantiate fixed 8-bit combinational multipliers.

Parameters:
M, 8, field width in bits (supported 3..16)
POLY, 9'h11D, primitive polynomial including x^M term, M+1 bits; default x^8+x^4+x^3+x^2+1

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  input may be accepted this cycle
in_a  in  M  multiplicand
in_b  in  M  multiplier
in_mode  in  1  0 = MUL, 1 = MAC
in_first  in  1  MAC only: start new sequence (acc treated as 0 before this term)
in_last  in  1  MAC only: final term; sum is emitted
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  M  product (MUL) or accumulated sum (MAC)
acc_open  out  1  MAC sequence in progress (first seen, last not yet retired)

Behaviour:
- Reset (async, any time, including mid-sequence): clears s1_valid, out_valid, out_data=0, acc=0, acc_open=0. in_ready reads 1 once rst is low.
- Handshakes:
  - advance = !out_valid || out_ready; in_ready = advance (combinational, no dependence on in_valid).
  - Input accepted when in_valid && in_ready.
  - Output retired when out_valid && out_ready.
  - out_data and out_valid hold stable while out_valid && !out_ready.
- Stage 1 (registered on advance):
  - s1_valid <= accept.
  - On accept: s1_prod <= carry-less product of in_a and in_b (2M-1 bits), plus mode/first/last.
- Stage 2 (on advance && s1_valid):
  - r = s1_prod reduced mod POLY (M bits).
  - MUL: out_data <= r, out_valid <= 1; acc untouched.
  - MAC: sum = (s1_first ? 0 : acc) ^ r.
    - s1_last=1: out_data <= sum, out_valid <= 1, acc <= 0.
    - s1_last=0: acc <= sum, out_valid <= 0 (no output for intermediate terms).
- On advance with no emitting stage-2 beat: out_valid <= 0.
- Latency: accept at edge N gives out_valid high after edge N+1 (2-cycle latency). Throughput is 1 beat/cycle with out_ready held high.
- Backpressure: the whole pipeline freezes when out_valid && !out_ready. No beat is lost or duplicated.
- acc_open:
  - Set when a MAC first beat retires stage 2 without last.
  - Cleared when a MAC last beat retires stage 2.
- Boundary cases:
  - first && last on one beat: single-term sum = product, emitted.
  - MAC beat without first and acc_open=0: accumulates onto acc=0. Legal, no error.
  - first while acc_open=1: previous partial sum discarded; new sequence starts.
  - MUL beats interleaved inside an open MAC sequence: emitted in order; acc preserved.
  - in_first/in_last ignored when in_mode=0.
  - Zero operand gives 0.
  - Reduction is exact for every product degree up to 2M-2.

Decomposition:
- gf_pkg holds:
  - default M and POLY constants (8, 9'h11D);
  - mode constants GF_MODE_MUL=0, GF_MODE_MAC=1;
  - a constant function building the (M-1)xM reduction matrix (rows x^M..x^(2M-2) mod POLY) from POLY.
- Sub-module gf2m_reduce (parameters M, POLY): purely combinational 2M-1 -> M reduction via that matrix. Instantiated in stage 2.
- Carry-less product is generated in the top level.

Test Plan:
- M=8 MUL, out_ready=1: (0x02,0x80) -> 0x1D; (0x80,0x80) -> 0x13; (0x00,0xFF) -> 0x00. Each out_valid exactly 2 cycles after accept, back-to-back with no bubbles.
- M=8 MAC sequence:
  - beats (0x02,0x80,first), (0x80,0x80), (0x01,0x55,last).
  - Exactly one output, 0x5B.
  - acc_open high from the cycle after the first term retires until the last term retires.
- Backpressure: stream 6 MUL beats with out_ready toggling 1,0,0,1,... -> in_ready mirrors advance; outputs match the golden model in order; out_data stable while stalled.
- Interleave/restart:
  - MAC first (0x02,0x80), MUL (0x03,0x03) -> 0x05 emitted;
  - then MAC first+last (0x04,0x04) -> 0x10; earlier partial sum discarded.
- Reset mid-sequence: assert rst asynchronously between MAC terms -> out_valid=0, acc_open=0 immediately. A following first+last (0x02,0x80) -> 0x1D.
- Parametrised instance M=4, POLY=5'h13: (0x8,0x2) -> 0x3; (0xF,0xF) -> 0xA. Random 1000-beat compare against a reference model.
